assoc_set: RTL and testbench

ASSOC_SET -- requirements
Module: assoc_set

---
 rtl/assoc_set.sv | 148 ++++++++++++++
 tb/tb_assoc_set.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_set.sv
// assoc_set: one set of an N-way set-associative cache with tag compare,
// per-way LRU ages and an enable/ack request handshake.
module assoc_set #(
    parameter int WAYS = 2,
    parameter int WORDS = 4,
    parameter int TAG_W = 5,
    parameter int DATA_W = 16,
    localparam int WAY_W = $clog2(WAYS),
    localparam int WORD_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              comp,
    input  logic              write,
    input  logic [WORD_W-1:0] word,
    input  logic [WAY_W-1:0]  way_in,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              hit,
    output logic              dirty_out,
    output logic              valid_out,
    output logic [TAG_W-1:0]  tag_out,
    output logic [DATA_W-1:0] data_out,
    output logic [WAY_W-1:0]  way_out,
    output logic              ack
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    state_t state;
    logic              r_comp;
    logic              r_write;
    logic [WORD_W-1:0] r_word;
    logic [WAY_W-1:0]  r_way;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic [WAYS-1:0]   valid;
    logic [WAYS-1:0]   dirty;
    logic [TAG_W-1:0]  tags [WAYS];
    logic [DATA_W-1:0] mem [WAYS][WORDS];
    logic [WAY_W-1:0]  age [WAYS];
    logic [WAY_W-1:0]  age_nxt [WAYS];
    logic              hit_any;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;
    logic [WAY_W-1:0]  sel;
    logic              touch;
    logic              do_write;
    logic              n_dirty;
    logic              n_valid;
    logic [TAG_W-1:0]  n_tag;
    logic [DATA_W-1:0] n_data;
    // Descending scans so the lowest matching / invalid index wins.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        victim = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == r_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(i);
            end
        end
        for (int i = WAYS - 1; i >= 0; i--)
            if (age[i] == WAY_W'(WAYS - 1)) victim = WAY_W'(i);
        for (int i = WAYS - 1; i >= 0; i--)
            if (!valid[i]) victim = WAY_W'(i);
    end
    always_comb begin
        sel = r_comp ? (hit_any ? hit_way : victim) : r_way;
        touch = r_comp ? hit_any : r_write;
        do_write = r_write && (!r_comp || hit_any);
        n_data = do_write ? r_data : mem[sel][r_word];
        n_tag = (do_write && !r_comp) ? r_tag : tags[sel];
        n_valid = (do_write && !r_comp) ? r_valid : valid[sel];
        n_dirty = do_write ? 1'b0 : dirty[sel];
    end
    // Touched way becomes youngest; only ways younger than it age by one.
    always_comb begin
        for (int i = 0; i < WAYS; i++)
            age_nxt[i] = (WAY_W'(i) == sel) ? '0
                       : (age[i] < age[sel]) ? age[i] + 1'b1 : age[i];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ack <= 1'b0;
            hit <= 1'b0;
            dirty_out <= 1'b0;
            valid_out <= 1'b0;
            tag_out <= '0;
            data_out <= '0;
            way_out <= '0;
            r_comp <= 1'b0;
            r_write <= 1'b0;
            r_word <= '0;
            r_way <= '0;
            r_tag <= '0;
            r_data <= '0;
            r_valid <= 1'b0;
            valid <= '0;
            dirty <= '0;
            for (int i = 0; i < WAYS; i++) begin
                tags[i] <= '0;
                age[i] <= WAY_W'(i);
                for (int j = 0; j < WORDS; j++) mem[i][j] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (enable) begin
                    state <= ACCESS;
                    r_comp <= comp;
                    r_write <= write;
                    r_word <= word;
                    r_way <= way_in;
                    r_tag <= tag_in;
                    r_data <= data_in;
                    r_valid <= valid_in;
                end
                ACCESS: begin
                    state <= ACK;
                    ack <= 1'b1;
                    hit <= r_comp && hit_any;
                    way_out <= sel;
                    data_out <= n_data;
                    tag_out <= n_tag;
                    valid_out <= n_valid;
                    dirty_out <= n_dirty;
                    if (do_write) begin
                        mem[sel][r_word] <= r_data;
                        dirty[sel] <= r_comp;
                        if (!r_comp) begin
                            tags[sel] <= r_tag;
                            valid[sel] <= r_valid;
                        end
                    end
                    if (touch) age <= age_nxt;
                end
                ACK: if (!enable) begin
                    state <= IDLE;
                    ack <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_assoc_set.sv
// tb_assoc_set: scoreboard-driven bench for assoc_set (WAYS=2, WORDS=4, TAG_W=5, DATA_W=16).
module tb_assoc_set;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        comp = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  word = '0;
    logic [0:0]  way_in = '0;
    logic [4:0]  tag_in = '0;
    logic [15:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        hit;
    logic        dirty_out;
    logic        valid_out;
    logic [4:0]  tag_out;
    logic [15:0] data_out;
    logic [0:0]  way_out;
    logic        ack;
    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        comp;
        logic        write;
        logic [1:0]  word;
        logic [0:0]  way;
        logic [4:0]  tag;
        logic [15:0] data;
        logic        valid;
    } req_t;

    // m selects optional fields: {dirty, valid, tag, data}
    typedef struct packed {
        logic        hit;
        logic [0:0]  way;
        logic [3:0]  m;
        logic        dirty;
        logic        valid;
        logic [4:0]  tag;
        logic [15:0] data;
    } exp_t;

    typedef struct packed {
        logic        ack0;
        logic        ack1;
        logic        ack2;
        logic        hit;
        logic        dirty;
        logic        valid;
        logic [4:0]  tag;
        logic [15:0] data;
        logic [0:0]  way;
        logic        hit2;
        logic [0:0]  way2;
    } obs_t;

    exp_t exp_q[$];

    assoc_set #(.WAYS(2), .WORDS(4), .TAG_W(5), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .comp(comp), .write(write),
        .word(word), .way_in(way_in), .tag_in(tag_in), .data_in(data_in),
        .valid_in(valid_in), .hit(hit), .dirty_out(dirty_out),
        .valid_out(valid_out), .tag_out(tag_out), .data_out(data_out),
        .way_out(way_out), .ack(ack)
    );

    always #5 clk = ~clk;

    function automatic req_t cr(input logic [4:0] t, input logic [1:0] w);
        cr = '{1'b1, 1'b0, w, 1'b0, t, 16'h0, 1'b0};
    endfunction
    function automatic req_t cw(input logic [4:0] t, input logic [1:0] w, input logic [15:0] d);
        cw = '{1'b1, 1'b1, w, 1'b0, t, d, 1'b0};
    endfunction
    function automatic req_t aw(input logic [0:0] y, input logic [1:0] w, input logic [4:0] t,
                                input logic [15:0] d, input logic v);
        aw = '{1'b0, 1'b1, w, y, t, d, v};
    endfunction
    function automatic req_t ar(input logic [0:0] y, input logic [1:0] w);
        ar = '{1'b0, 1'b0, w, y, 5'h0, 16'h0, 1'b0};
    endfunction
    function automatic exp_t ex(input logic h, input logic [0:0] y, input logic [3:0] m,
                                input logic d, input logic v, input logic [4:0] t, input logic [15:0] x);
        ex = '{h, y, m, d, v, t, x};
    endfunction

    // One full handshake; request inputs are scrambled right after they are latched.
    task automatic do_req(input req_t r, output obs_t o);
        @(negedge clk);
        comp = r.comp; write = r.write; word = r.word; way_in = r.way;
        tag_in = r.tag; data_in = r.data; valid_in = r.valid; enable = 1'b1;
        @(posedge clk); #1;
        o.ack0 = ack;
        comp = ~r.comp; write = ~r.write; word = ~r.word; way_in = ~r.way;
        tag_in = ~r.tag; data_in = ~r.data; valid_in = ~r.valid;
        @(posedge clk); #1;
        o.ack1 = ack; o.hit = hit; o.dirty = dirty_out; o.valid = valid_out;
        o.tag = tag_out; o.data = data_out; o.way = way_out;
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        o.ack2 = ack; o.hit2 = hit; o.way2 = way_out;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL reset ack: got %b want 0", ack);
        end
        checks++;
        if ({hit, dirty_out, valid_out, tag_out, data_out, way_out} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %b %b %b %h %h %b want all 0",
                     hit, dirty_out, valid_out, tag_out, data_out, way_out);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_table(input string nm, input req_t rq[$], input exp_t eq[$]);
        obs_t o;
        exp_t e;
        for (int i = 0; i < rq.size(); i++) begin
            exp_q.push_back(eq[i]);
            do_req(rq[i], o);
            e = exp_q.pop_front();
            checks++;
            if ({o.ack0, o.ack1, o.ack2} !== 3'b010) begin
                errors++;
                $display("FAIL %s[%0d] ack timing: got %b%b%b want 010", nm, i, o.ack0, o.ack1, o.ack2);
            end
            checks++;
            if (o.hit !== e.hit) begin
                errors++;
                $display("FAIL %s[%0d] hit: got %b want %b", nm, i, o.hit, e.hit);
            end
            checks++;
            if (o.way !== e.way) begin
                errors++;
                $display("FAIL %s[%0d] way_out: got %0d want %0d", nm, i, o.way, e.way);
            end
            checks++;
            if ({o.hit2, o.way2} !== {e.hit, e.way}) begin
                errors++;
                $display("FAIL %s[%0d] hold after ack: got hit=%b way=%0d want hit=%b way=%0d",
                         nm, i, o.hit2, o.way2, e.hit, e.way);
            end
            if (e.m[3]) begin
                checks++;
                if (o.dirty !== e.dirty) begin
                    errors++;
                    $display("FAIL %s[%0d] dirty_out: got %b want %b", nm, i, o.dirty, e.dirty);
                end
            end
            if (e.m[2]) begin
                checks++;
                if (o.valid !== e.valid) begin
                    errors++;
                    $display("FAIL %s[%0d] valid_out: got %b want %b", nm, i, o.valid, e.valid);
                end
            end
            if (e.m[1]) begin
                checks++;
                if (o.tag !== e.tag) begin
                    errors++;
                    $display("FAIL %s[%0d] tag_out: got %h want %h", nm, i, o.tag, e.tag);
                end
            end
            if (e.m[0]) begin
                checks++;
                if (o.data !== e.data) begin
                    errors++;
                    $display("FAIL %s[%0d] data_out: got %h want %h", nm, i, o.data, e.data);
                end
            end
        end
    endtask

    task automatic test_compare;
        req_t rq[$];
        exp_t eq[$];
        rq.push_back(cr(5'h03, 2'd0));                 eq.push_back(ex(1'b0, 1'b0, 4'b1110, 1'b0, 1'b0, 5'h00, 16'h0));
        rq.push_back(aw(1'b1, 2'd2, 5'h0A, 16'hBEEF, 1'b1)); eq.push_back(ex(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 5'h00, 16'h0));
        rq.push_back(cr(5'h0A, 2'd2));                 eq.push_back(ex(1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 5'h0A, 16'hBEEF));
        rq.push_back(cw(5'h0A, 2'd2, 16'h1234));       eq.push_back(ex(1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 5'h00, 16'h0));
        rq.push_back(cr(5'h0A, 2'd2));                 eq.push_back(ex(1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 5'h0A, 16'h1234));
        rq.push_back(cr(5'h11, 2'd0));                 eq.push_back(ex(1'b0, 1'b0, 4'b1110, 1'b0, 1'b0, 5'h00, 16'h0));
        rq.push_back(ar(1'b1, 2'd2));                  eq.push_back(ex(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 5'h0A, 16'h1234));
        run_table("compare", rq, eq);
    endtask

    task automatic test_lru_victim;
        req_t rq[$];
        exp_t eq[$];
        rq.push_back(aw(1'b0, 2'd0, 5'h01, 16'h1111, 1'b1)); eq.push_back(ex(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 5'h00, 16'h0));
        rq.push_back(aw(1'b1, 2'd0, 5'h02, 16'h2222, 1'b1)); eq.push_back(ex(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 5'h00, 16'h0));
        rq.push_back(cr(5'h01, 2'd0));                 eq.push_back(ex(1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 5'h01, 16'h1111));
        rq.push_back(cr(5'h03, 2'd0));                 eq.push_back(ex(1'b0, 1'b1, 4'b1110, 1'b0, 1'b1, 5'h02, 16'h0));
        rq.push_back(cr(5'h04, 2'd0));                 eq.push_back(ex(1'b0, 1'b1, 4'b1110, 1'b0, 1'b1, 5'h02, 16'h0));
        rq.push_back(aw(1'b1, 2'd0, 5'h07, 16'h0000, 1'b0)); eq.push_back(ex(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 5'h00, 16'h0));
        rq.push_back(cr(5'h09, 2'd0));                 eq.push_back(ex(1'b0, 1'b1, 4'b1110, 1'b0, 1'b0, 5'h07, 16'h0));
        rq.push_back(aw(1'b1, 2'd0, 5'h01, 16'h5555, 1'b1)); eq.push_back(ex(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 5'h00, 16'h0));
        rq.push_back(cr(5'h01, 2'd0));                 eq.push_back(ex(1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 5'h01, 16'h1111));
        rq.push_back(cw(5'h02, 2'd0, 16'hABCD));       eq.push_back(ex(1'b0, 1'b1, 4'b1110, 1'b0, 1'b1, 5'h01, 16'h0));
        rq.push_back(ar(1'b1, 2'd0));                  eq.push_back(ex(1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 5'h01, 16'h5555));
        run_table("lru", rq, eq);
    endtask

    task automatic test_reset_mid;
        req_t rq[$];
        exp_t eq[$];
        @(negedge clk);
        comp = 1'b0; write = 1'b1; word = 2'd3; way_in = 1'b1;
        tag_in = 5'h0C; data_in = 16'hCAFE; valid_in = 1'b1; enable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ack !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid ack[%0d]: got %b want 0", i, ack);
            end
            @(posedge clk);
        end
        @(negedge clk);
        enable = 1'b0;
        rst = 1'b1;
        rq.push_back(ar(1'b1, 2'd3)); eq.push_back(ex(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 5'h00, 16'h0));
        rq.push_back(ar(1'b1, 2'd0)); eq.push_back(ex(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 5'h00, 16'h0));
        rq.push_back(cr(5'h00, 2'd0)); eq.push_back(ex(1'b0, 1'b0, 4'b1110, 1'b0, 1'b0, 5'h00, 16'h0));
        run_table("reset_mid", rq, eq);
    endtask

    task automatic test_hold_ack;
        int n;
        req_t rq[$];
        exp_t eq[$];
        exp_t e;
        n = 0;
        exp_q.push_back(ex(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 5'h00, 16'd5));
        @(negedge clk);
        comp = 1'b0; write = 1'b0; word = 2'd0; way_in = 1'b0; enable = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) n++;
        end
        @(negedge clk);
        enable = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (16'(n) !== e.data) begin
            errors++;
            $display("FAIL hold_ack cycles: got %0d want %0d", n, e.data);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ack !== 1'b0) begin
                errors++;
                $display("FAIL hold_ack release[%0d]: got %b want 0", i, ack);
            end
        end
        rq.push_back(ar(1'b0, 2'd0)); eq.push_back(ex(1'b0, 1'b0, 4'b0101, 1'b0, 1'b0, 5'h00, 16'h0));
        run_table("hold_ack", rq, eq);
    endtask

    initial begin
        test_reset;
        test_compare;
        test_lru_victim;
        test_reset_mid;
        test_hold_ack;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
